fft_r22_stage: RTL and testbench

FFT_R22_STAGE -- requirements
Module: fft_r22_stage

---
 rtl/fft_pkg.sv | 75 +++++++
 rtl/fft_sdf_delay.sv | 28 ++
 rtl/fft_r22_stage.sv | 132 +++++++++++++
 tb/tb_fft_r22_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2^2 SDF FFT stage: complex
// pack/unpack, the trivial -j rotation, output saturation and width constants.
package fft_pkg;

  // Internal complex sample: components carried at 32 bits so the butterfly
  // sums never wrap, then narrowed only where they are stored or emitted.
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  localparam int CPLX_BITS = 32;
  localparam int BUS_BITS  = 64;

  // Frame counter width for a BF-I delay of depth (frame = 2*depth).
  function automatic int cnt_width(input int depth);
    return $clog2(2 * depth);
  endfunction

  // Fill counter width: must be able to hold 3*depth/2.
  function automatic int fill_width(input int depth);
    return $clog2(3 * depth / 2 + 1);
  endfunction

  // Split a {re,im} bus of nbits per component into sign-extended parts.
  function automatic cplx_t unpack_cplx(input logic [63:0] bus, input int nbits);
    cplx_t c;
    logic signed [63:0] t;
    t    = signed'(bus << (BUS_BITS - 2 * nbits));
    c.re = 32'(t >>> (BUS_BITS - nbits));
    t    = signed'(bus << (BUS_BITS - nbits));
    c.im = 32'(t >>> (BUS_BITS - nbits));
    return c;
  endfunction

  // Pack the low nbits of each component into a {re,im} bus.
  function automatic logic [63:0] pack_cplx(input cplx_t c, input int nbits);
    logic [63:0] mask;
    mask = (64'd1 << nbits) - 64'd1;
    return ((64'(c.re) & mask) << nbits) | (64'(c.im) & mask);
  endfunction

  // Multiply by -j: (re,im) -> (im,-re).
  function automatic cplx_t rot_mj(input cplx_t c);
    cplx_t r;
    r.re = c.im;
    r.im = -c.re;
    return r;
  endfunction

  // Map a w_in-bit value to w_out bits: left-justify when widening,
  // clamp to the signed range when narrowing.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int w_in, input int w_out);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w_out - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (w_out >= w_in) return v <<< (w_out - w_in);
    else if (v > hi)   return hi;
    else if (v < lo)   return lo;
    else               return v;
  endfunction

  // True when saturate() would have to clamp this value.
  function automatic logic clamps(input logic signed [31:0] v,
                                  input int w_in, input int w_out);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w_out - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return (w_out < w_in) && ((v > hi) || (v < lo));
  endfunction

endpackage

// File: rtl/fft_sdf_delay.sv
// Enable-gated feedback delay line used by each SDF butterfly. The oldest
// entry is presented on head; a new word enters only when en is high.
module fft_sdf_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift register: clears on reset, advances one slot per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign head = mem[DEPTH-1];

endmodule

// File: rtl/fft_r22_stage.sv
// One single-path radix-2^2 SDF stage: BF-I (delay DEPTH), trivial -j
// rotation, BF-II (delay DEPTH/2), then width mapping and an output register.
// Optional sticky saturation flag enabled by defining FFT_R22_OVF_EN.
module fft_r22_stage
  import fft_pkg::*;
#(
  parameter int NBITS_IN  = 10,
  parameter int NBITS_OUT = 15,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2*NBITS_IN-1:0]  in_data,
  output logic                   out_valid,
  output logic [2*NBITS_OUT-1:0] out_data,
  output logic                   ovf
);

  localparam int W1       = NBITS_IN + 1;
  localparam int W        = NBITS_IN + 2;
  localparam int CNT_W    = cnt_width(DEPTH);
  localparam int FILL_W   = fill_width(DEPTH);
  localparam int D1_BITS  = 2 * W1;
  localparam int D2_BITS  = 2 * W;
  localparam int OUT_BITS = 2 * NBITS_OUT;
  localparam logic [FILL_W-1:0] FILL_TARGET = FILL_W'(3 * DEPTH / 2);

  logic [CNT_W-1:0]   cnt;
  logic [FILL_W-1:0]  fill;
  logic [D1_BITS-1:0] d1_in;
  logic [D1_BITS-1:0] d1_head;
  logic [D2_BITS-1:0] d2_in;
  logic [D2_BITS-1:0] d2_head;
  logic               sec1;
  logic               sec2;
  cplx_t              x;
  cplx_t              h1;
  cplx_t              bf1;
  cplx_t              diff1;
  cplx_t              rot;
  cplx_t              h2;
  cplx_t              y;
  cplx_t              diff2;
  cplx_t              res;

  assign sec1 = cnt[CNT_W-1];
  assign sec2 = cnt[CNT_W-2];

  fft_sdf_delay #(.WIDTH(D1_BITS), .DEPTH(DEPTH)) bf1_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (d1_in),
    .head (d1_head)
  );

  fft_sdf_delay #(.WIDTH(D2_BITS), .DEPTH(DEPTH / 2)) bf2_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (d2_in),
    .head (d2_head)
  );

  // Datapath: both butterflies, the -j twiddle and the output width mapping.
  always_comb begin
    x     = unpack_cplx(64'(in_data), NBITS_IN);
    h1    = unpack_cplx(64'(d1_head), W1);
    bf1   = h1;
    diff1 = x;
    if (sec1) begin
      bf1.re   = h1.re + x.re;
      bf1.im   = h1.im + x.im;
      diff1.re = h1.re - x.re;
      diff1.im = h1.im - x.im;
    end
    d1_in = D1_BITS'(pack_cplx(diff1, W1));

    rot = (!sec1 && sec2) ? rot_mj(bf1) : bf1;

    h2    = unpack_cplx(64'(d2_head), W);
    y     = h2;
    diff2 = rot;
    if (sec2) begin
      y.re     = h2.re + rot.re;
      y.im     = h2.im + rot.im;
      diff2.re = h2.re - rot.re;
      diff2.im = h2.im - rot.im;
    end
    d2_in = D2_BITS'(pack_cplx(diff2, W));

    res.re = saturate(y.re, W, NBITS_OUT);
    res.im = saturate(y.im, W, NBITS_OUT);
  end

  // Frame position and saturating fill count, advanced only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      fill <= '0;
    end else if (in_valid) begin
      cnt <= cnt + CNT_W'(1);
      if (fill != FILL_TARGET) fill <= fill + FILL_W'(1);
    end
  end

  // Output register: data holds between accepted samples, valid once the pipe is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid && (fill == FILL_TARGET);
      if (in_valid) out_data <= OUT_BITS'(pack_cplx(res, NBITS_OUT));
    end
  end

`ifdef FFT_R22_OVF_EN
  // Sticky flag: latches any clamp on an accepted sample until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid && (clamps(y.re, W, NBITS_OUT) || clamps(y.im, W, NBITS_OUT))) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_r22_stage.sv
// Scoreboard bench for fft_r22_stage. Three instances cover DEPTH=2 with
// 15-bit outputs, DEPTH=16, and DEPTH=2 with 11-bit (clamping) outputs.
// Only the selected instance is out of reset; a monitor pops expectations.
module tb_fft_r22_stage;

  typedef struct {
    int re;
    int im;
  } exp_t;

`ifdef FFT_R22_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        drv_rst = 1'b1;
  logic        drv_valid = 1'b0;
  logic [9:0]  drv_re = '0;
  logic [9:0]  drv_im = '0;
  logic [19:0] drv_data;
  int          sel = 0;
  string       cur_test = "init";

  logic        rst_a, rst_b, rst_c;
  logic        valid_a, valid_b, valid_c;
  logic        ov_a, ov_b, ov_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [29:0] od_a, od_b;
  logic [21:0] od_c;

  logic        cur_valid;
  logic        cur_ovf;
  int          cur_re, cur_im;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          drain_tag = 0;
  int          ovf_tag = 0;
  bit          ovf_exp = 1'b0;

  always #5 clk = ~clk;

  assign drv_data = {drv_re, drv_im};
  assign rst_a    = drv_rst || (sel != 0);
  assign rst_b    = drv_rst || (sel != 1);
  assign rst_c    = drv_rst || (sel != 2);
  assign valid_a  = drv_valid && (sel == 0);
  assign valid_b  = drv_valid && (sel == 1);
  assign valid_c  = drv_valid && (sel == 2);

  fft_r22_stage #(.NBITS_IN(10), .NBITS_OUT(15), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_data(drv_data),
    .out_valid(ov_a), .out_data(od_a), .ovf(ovf_a)
  );

  fft_r22_stage #(.NBITS_IN(10), .NBITS_OUT(15), .DEPTH(16)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_data(drv_data),
    .out_valid(ov_b), .out_data(od_b), .ovf(ovf_b)
  );

  fft_r22_stage #(.NBITS_IN(10), .NBITS_OUT(11), .DEPTH(2)) dut_c (
    .clk(clk), .rst(rst_c), .in_valid(valid_c), .in_data(drv_data),
    .out_valid(ov_c), .out_data(od_c), .ovf(ovf_c)
  );

  // View of whichever instance is currently under test.
  always_comb begin
    cur_valid = 1'b0;
    cur_ovf   = 1'b0;
    cur_re    = 0;
    cur_im    = 0;
    case (sel)
      0: begin
        cur_valid = ov_a;
        cur_ovf   = ovf_a;
        cur_re    = int'($signed(od_a[29:15]));
        cur_im    = int'($signed(od_a[14:0]));
      end
      1: begin
        cur_valid = ov_b;
        cur_ovf   = ovf_b;
        cur_re    = int'($signed(od_b[29:15]));
        cur_im    = int'($signed(od_b[14:0]));
      end
      default: begin
        cur_valid = ov_c;
        cur_ovf   = ovf_c;
        cur_re    = int'($signed(od_c[21:11]));
        cur_im    = int'($signed(od_c[10:0]));
      end
    endcase
  end

  // Monitor: reset state, hold behaviour, scoreboard pops and end-of-test requests.
  bit prev_rst = 1'b1;
  bit prev_valid = 1'b0;
  int prev_sel = 0;
  int prev_re = 0;
  int prev_im = 0;
  int drain_seen = 0;
  int ovf_seen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      checks++;
      if (cur_valid !== 1'b0 || cur_re != 0 || cur_im != 0 || cur_ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state (%s): got valid=%0b data=(%0d,%0d) ovf=%0b, required valid=0 data=(0,0) ovf=0",
                 cur_test, cur_valid, cur_re, cur_im, cur_ovf);
      end
    end else if (!prev_valid && sel == prev_sel) begin
      checks++;
      if (cur_valid !== 1'b0 || cur_re != prev_re || cur_im != prev_im) begin
        errors++;
        $display("[TB] FAIL hold (%s): got valid=%0b data=(%0d,%0d), required valid=0 data=(%0d,%0d)",
                 cur_test, cur_valid, cur_re, cur_im, prev_re, prev_im);
      end
    end
    if (cur_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid (%s): got data=(%0d,%0d), required no output",
                 cur_test, cur_re, cur_im);
      end else begin
        e = exp_q.pop_front();
        if (cur_re != e.re || cur_im != e.im) begin
          errors++;
          $display("[TB] FAIL sample (%s): got (%0d,%0d), required (%0d,%0d)",
                   cur_test, cur_re, cur_im, e.re, e.im);
        end
      end
    end
    if (drain_tag != drain_seen) begin
      drain_seen = drain_tag;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL drain (%s): got %0d pending outputs, required 0", cur_test, exp_q.size());
        exp_q.delete();
      end
    end
    if (ovf_tag != ovf_seen) begin
      ovf_seen = ovf_tag;
      checks++;
      if (cur_ovf !== ovf_exp) begin
        errors++;
        $display("[TB] FAIL ovf (%s): got %0b, required %0b", cur_test, cur_ovf, ovf_exp);
      end
    end
    prev_rst   = drv_rst;
    prev_valid = drv_valid;
    prev_sel   = sel;
    prev_re    = cur_re;
    prev_im    = cur_im;
  end

  task automatic reset_dut(input int id, input string name);
    @(posedge clk);
    #1;
    drv_rst   = 1'b1;
    drv_valid = 1'b0;
    sel       = id;
    cur_test  = name;
    $display("[TB] running %s", name);
    @(posedge clk);
    #1;
    drv_rst = 1'b0;
  endtask

  task automatic apply_stimulus(input bit valid, input int re, input int im,
                                input bit has_exp, input int exp_re, input int exp_im);
    exp_t e;
    @(posedge clk);
    #1;
    drv_rst   = 1'b0;
    drv_valid = valid;
    drv_re    = 10'(re);
    drv_im    = 10'(im);
    if (has_exp) begin
      e.re = exp_re;
      e.im = exp_im;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_output(input bit do_ovf, input bit ovf_val);
    apply_stimulus(1'b0, 0, 0, 1'b0, 0, 0);
    apply_stimulus(1'b0, 0, 0, 1'b0, 0, 0);
    ovf_exp = ovf_val;
    if (do_ovf) ovf_tag++;
    drain_tag++;
    repeat (2) @(negedge clk);
  endtask

  // Impulse (100,0) at sample 8 of a DEPTH=16 frame: bins X0,X2,X1,X3 at 24,32,40,48.
  function automatic exp_t tone8_exp(input int i);
    exp_t e;
    e.re = 0;
    e.im = 0;
    if (i == 24) e.re = 800;
    if (i == 32) e.re = -800;
    if (i == 40) e.im = -800;
    if (i == 48) e.im = 800;
    return e;
  endfunction

  initial begin
    int   tone_re[4];
    int   tone_im[4];
    exp_t e;
    tone_re = '{-800, 0, 0, 800};
    tone_im = '{0, -800, 800, 0};

    // Constant (100,0), DEPTH=2: 3200 at cnt=3, zeros elsewhere.
    reset_dut(0, "const_depth2");
    for (int i = 0; i < 12; i++)
      apply_stimulus(1'b1, 100, 0, i >= 3, (i % 4 == 3) ? 3200 : 0, 0);
    check_output(1'b1, 1'b0);

    // Single tone at n=1, DEPTH=2: bit-reversed bins including the -j leg.
    reset_dut(0, "tone_depth2");
    for (int i = 0; i < 12; i++)
      apply_stimulus(1'b1, (i % 4 == 1) ? 100 : 0, 0, i >= 3, tone_re[i % 4], tone_im[i % 4]);
    check_output(1'b0, 1'b0);

    // Positive clamp with 11-bit outputs: 4*511 -> 1023.
    reset_dut(2, "sat_pos");
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, 511, 0, i >= 3, (i % 4 == 3) ? 1023 : 0, 0);
    check_output(1'b1, OVF_ON);

    // Negative clamp on both components: 4*(-512) -> -1024.
    reset_dut(2, "sat_neg");
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, -512, -512, i >= 3, (i % 4 == 3) ? -1024 : 0, (i % 4 == 3) ? -1024 : 0);
    check_output(1'b1, OVF_ON);

    // DEPTH=16 impulse at sample 8, gap-free.
    reset_dut(1, "tone8_nostall");
    for (int i = 0; i < 56; i++) begin
      e = tone8_exp(i);
      apply_stimulus(1'b1, (i == 8) ? 100 : 0, 0, i >= 24, e.re, e.im);
    end
    check_output(1'b0, 1'b0);

    // Same sequence with in_valid toggling and junk data in the idle cycles.
    reset_dut(1, "tone8_stall");
    for (int i = 0; i < 56; i++) begin
      e = tone8_exp(i);
      apply_stimulus(1'b1, (i == 8) ? 100 : 0, 0, i >= 24, e.re, e.im);
      apply_stimulus(1'b0, 77, -33, 1'b0, 0, 0);
    end
    check_output(1'b0, 1'b0);

    // Mid-frame reset (asserted together with in_valid) then impulse at sample 0.
    reset_dut(1, "reset_midframe");
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b1, 300, -200, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    drv_rst   = 1'b1;
    drv_valid = 1'b1;
    drv_re    = 10'(300);
    drv_im    = 10'(-200);
    for (int i = 0; i < 56; i++) begin
      bit hit;
      hit = (i == 24) || (i == 32) || (i == 40) || (i == 48);
      apply_stimulus(1'b1, (i == 0) ? 256 : 0, 0, i >= 24, hit ? 2048 : 0, 0);
    end
    check_output(1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
